// File: rtl/alarm_siren_ctrl_pkg.sv
// Shared types and constants for the alarm siren controller.
// State encodings are visible on state_o and must not be renumbered.
package alarm_siren_ctrl_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned TRIP_W  = 4;
    localparam logic [TRIP_W-1:0] TRIP_MAX = 4'd15;

    typedef enum logic [STATE_W-1:0] {
        StDisarmed   = 3'd0,
        StExitDelay  = 3'd1,
        StArmed      = 3'd2,
        StEntryDelay = 3'd3,
        StSiren      = 3'd4
    } state_e;

    function automatic logic [TRIP_W-1:0] trip_sat_inc(input logic [TRIP_W-1:0] val);
        return (val == TRIP_MAX) ? val : val + 1'b1;
    endfunction

endpackage

// File: rtl/alarm_siren_ctrl_if.sv
// Decoder/user inputs and siren/status outputs of the alarm siren controller.
// The controller uses the slave modport; whoever drives the inputs uses master.
interface alarm_siren_ctrl_if;
    import alarm_siren_ctrl_pkg::*;

    logic              alarm_set;
    logic              secure;
    logic              alarm;
    logic              siren;
    logic              armed;
    logic              pending;
    logic [STATE_W-1:0] state_o;
    logic [TRIP_W-1:0]  trip_count;

    modport master (
        output alarm_set, secure, alarm,
        input  siren, armed, pending, state_o, trip_count
    );

    modport slave (
        input  alarm_set, secure, alarm,
        output siren, armed, pending, state_o, trip_count
    );

endinterface

// File: rtl/alarm_delay_cnt.sv
// Loadable down-counter for the exit, entry and siren delays.
// Load has priority over enable; the count holds at zero instead of wrapping.
module alarm_delay_cnt #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/alarm_siren_ctrl.sv
// Alarm controller: exit delay, entry delay, timed siren and saturating trip counter.
// Moore outputs decoded from the registered state; disarm overrides everything.
module alarm_siren_ctrl
    import alarm_siren_ctrl_pkg::*;
#(
    parameter int unsigned EXIT_CYCLES  = 16,
    parameter int unsigned ENTRY_CYCLES = 8,
    parameter int unsigned SIREN_CYCLES = 32,
    parameter int unsigned CNT_W        = 8
) (
    input  logic               clk,
    input  logic               reset,
    alarm_siren_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] ExitLoad  = CNT_W'(EXIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] EntryLoad = CNT_W'(ENTRY_CYCLES - 1);
    localparam logic [CNT_W-1:0] SirenLoad = CNT_W'(SIREN_CYCLES - 1);

    state_e            state_q, state_d;
    logic [TRIP_W-1:0] trip_q, trip_d;
    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_load_val;
    logic              cnt_en;
    logic              cnt_zero;

    alarm_delay_cnt #(
        .CNT_W (CNT_W)
    ) u_delay_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        trip_d       = trip_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_en       = 1'b0;

        if (!bus.alarm_set) begin
            state_d  = StDisarmed;
            cnt_load = 1'b1;
        end else begin
            unique case (state_q)
                StDisarmed: begin
                    if (bus.secure) begin
                        state_d      = StExitDelay;
                        cnt_load     = 1'b1;
                        cnt_load_val = ExitLoad;
                    end
                end
                StExitDelay: begin
                    if (cnt_zero) begin
                        state_d = StArmed;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                StArmed: begin
                    if (bus.alarm) begin
                        state_d      = StEntryDelay;
                        cnt_load     = 1'b1;
                        cnt_load_val = EntryLoad;
                    end
                end
                StEntryDelay: begin
                    if (cnt_zero) begin
                        state_d      = StSiren;
                        cnt_load     = 1'b1;
                        cnt_load_val = SirenLoad;
                        trip_d       = trip_sat_inc(trip_q);
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                StSiren: begin
                    if (!cnt_zero) begin
                        cnt_en = 1'b1;
                    end else if (bus.alarm) begin
                        // Continuing intrusion extends the siren without counting a new trip.
                        cnt_load     = 1'b1;
                        cnt_load_val = SirenLoad;
                    end else begin
                        state_d = StArmed;
                    end
                end
                default: begin
                    state_d  = StDisarmed;
                    cnt_load = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StDisarmed;
            trip_q  <= '0;
        end else begin
            state_q <= state_d;
            trip_q  <= trip_d;
        end
    end

    always_comb begin
        bus.pending    = (state_q == StExitDelay) || (state_q == StEntryDelay);
        bus.armed      = (state_q == StArmed) || (state_q == StEntryDelay) ||
                         (state_q == StSiren);
        bus.siren      = (state_q == StSiren);
        bus.state_o    = state_q;
        bus.trip_count = trip_q;
    end

endmodule

// File: tb/tb_alarm_siren_ctrl.sv
// Self-checking bench for alarm_siren_ctrl with EXIT=4, ENTRY=3, SIREN=5.
// Expected outputs are queued when inputs are driven and popped after the edge.
module tb_alarm_siren_ctrl;

    logic clk;
    logic reset;

    alarm_siren_ctrl_if bus ();

    alarm_siren_ctrl #(
        .EXIT_CYCLES  (4),
        .ENTRY_CYCLES (3),
        .SIREN_CYCLES (5),
        .CNT_W        (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // sap = {siren, armed, pending}
    typedef struct packed {
        logic [2:0] st;
        logic [2:0] sap;
        logic [3:0] tr;
    } exp_t;

    typedef struct {
        logic as;
        logic sec;
        logic al;
        exp_t exp;
    } vec_t;

    exp_t  sb[$];
    vec_t  tbl[$];
    int    checks = 0;
    int    errors = 0;
    int    trip_exp;

    function automatic vec_t v(input logic as, input logic sec, input logic al,
                               input logic [2:0] st, input logic [2:0] sap,
                               input logic [3:0] tr);
        vec_t r;
        r.as  = as;
        r.sec = sec;
        r.al  = al;
        r.exp = '{st: st, sap: sap, tr: tr};
        return r;
    endfunction

    task automatic compare(input string name);
        exp_t e, a;
        a = '{st: bus.state_o, sap: {bus.siren, bus.armed, bus.pending}, tr: bus.trip_count};
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got st=%0d sap=%b trip=%0d",
                     name, a.st, a.sap, a.tr);
        end else begin
            e = sb.pop_front();
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got st=%0d sap=%b trip=%0d, want st=%0d sap=%b trip=%0d",
                         name, a.st, a.sap, a.tr, e.st, e.sap, e.tr);
            end
        end
    endtask

    task automatic step(input logic as, input logic sec, input logic al,
                        input logic [2:0] st, input logic [2:0] sap, input int tr,
                        input string name);
        bus.alarm_set = as;
        bus.secure    = sec;
        bus.alarm     = al;
        sb.push_back('{st: st, sap: sap, tr: 4'(tr)});
        @(posedge clk);
        #1;
        compare(name);
    endtask

    task automatic arm_seq(input int tr);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 3'd1, 3'b001, tr, "arm_exit");
        step(1, 1, 0, 3'd2, 3'b010, tr, "arm_armed");
    endtask

    // From ARMED: one alarm pulse, full entry delay and siren, back to ARMED.
    task automatic trip_once(input int tr_after);
        step(1, 1, 1, 3'd3, 3'b011, tr_after - 1 + ((tr_after == 15 && trip_exp == 15) ? 1 : 0),
             "trip_entry");
        for (int i = 0; i < 2; i++) step(1, 1, 0, 3'd3, 3'b011, trip_exp, "trip_entry");
        for (int i = 0; i < 5; i++) step(1, 1, 0, 3'd4, 3'b110, tr_after, "trip_siren");
        step(1, 1, 0, 3'd2, 3'b010, tr_after, "trip_rearmed");
    endtask

    initial begin
        bus.alarm_set = 1'b0;
        bus.secure    = 1'b0;
        bus.alarm     = 1'b0;

        // Exit delay then armed
        for (int i = 0; i < 4; i++) tbl.push_back(v(1, 1, 0, 3'd1, 3'b001, 0));
        tbl.push_back(v(1, 1, 0, 3'd2, 3'b010, 0));
        // Alarm pulse: entry delay, siren, back to armed
        tbl.push_back(v(1, 1, 1, 3'd3, 3'b011, 0));
        for (int i = 0; i < 2; i++) tbl.push_back(v(1, 1, 0, 3'd3, 3'b011, 0));
        for (int i = 0; i < 5; i++) tbl.push_back(v(1, 1, 0, 3'd4, 3'b110, 1));
        tbl.push_back(v(1, 1, 0, 3'd2, 3'b010, 1));
        // Disarm, unsecured arm attempts, then secure
        tbl.push_back(v(0, 1, 0, 3'd0, 3'b000, 1));
        for (int i = 0; i < 10; i++) tbl.push_back(v(1, 0, 0, 3'd0, 3'b000, 1));
        tbl.push_back(v(1, 1, 0, 3'd1, 3'b001, 1));
        tbl.push_back(v(0, 1, 0, 3'd0, 3'b000, 1));
        // Alarm ignored in exit delay; disarm during entry delay
        for (int i = 0; i < 4; i++) tbl.push_back(v(1, 1, 1, 3'd1, 3'b001, 1));
        tbl.push_back(v(1, 1, 1, 3'd2, 3'b010, 1));
        tbl.push_back(v(1, 1, 1, 3'd3, 3'b011, 1));
        tbl.push_back(v(0, 1, 0, 3'd0, 3'b000, 1));
        // Disarm coincident with entry expiry wins
        for (int i = 0; i < 4; i++) tbl.push_back(v(1, 1, 0, 3'd1, 3'b001, 1));
        tbl.push_back(v(1, 1, 0, 3'd2, 3'b010, 1));
        tbl.push_back(v(1, 1, 1, 3'd3, 3'b011, 1));
        for (int i = 0; i < 2; i++) tbl.push_back(v(1, 1, 0, 3'd3, 3'b011, 1));
        tbl.push_back(v(0, 1, 0, 3'd0, 3'b000, 1));

        reset = 1'b1;
        #12;
        sb.push_back('{st: 3'd0, sap: 3'b000, tr: 4'd0});
        compare("reset_state");
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            bus.alarm_set = tbl[i].as;
            bus.secure    = tbl[i].sec;
            bus.alarm     = tbl[i].al;
            sb.push_back(tbl[i].exp);
            @(posedge clk);
            #1;
            compare($sformatf("table[%0d]", i));
        end

        // Alarm held through siren expiry: siren reloads, no extra trip
        arm_seq(1);
        step(1, 1, 1, 3'd3, 3'b011, 1, "hold_entry");
        for (int i = 0; i < 2; i++) step(1, 1, 1, 3'd3, 3'b011, 1, "hold_entry");
        for (int i = 0; i < 10; i++) step(1, 1, 1, 3'd4, 3'b110, 2, "hold_siren");
        step(1, 1, 0, 3'd2, 3'b010, 2, "hold_rearmed");

        // Repeated trips until the counter saturates
        trip_exp = 2;
        for (int n = 0; n < 15; n++) begin
            step(1, 1, 1, 3'd3, 3'b011, trip_exp, "sat_entry");
            for (int i = 0; i < 2; i++) step(1, 1, 0, 3'd3, 3'b011, trip_exp, "sat_entry");
            trip_exp = (trip_exp < 15) ? trip_exp + 1 : 15;
            for (int i = 0; i < 5; i++) step(1, 1, 0, 3'd4, 3'b110, trip_exp, "sat_siren");
            step(1, 1, 0, 3'd2, 3'b010, trip_exp, "sat_rearmed");
        end

        // Asynchronous reset mid-siren clears everything before the next edge
        step(1, 1, 1, 3'd3, 3'b011, 15, "rst_entry");
        for (int i = 0; i < 2; i++) step(1, 1, 0, 3'd3, 3'b011, 15, "rst_entry");
        step(1, 1, 0, 3'd4, 3'b110, 15, "rst_siren");
        step(1, 1, 0, 3'd4, 3'b110, 15, "rst_siren");
        #2;
        reset = 1'b1;
        #1;
        sb.push_back('{st: 3'd0, sap: 3'b000, tr: 4'd0});
        compare("async_reset");
        #1;
        reset = 1'b0;
        step(1, 1, 0, 3'd1, 3'b001, 0, "post_reset_arm");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, want completion");
        $fatal(1);
    end

endmodule
